// File: rtl/proc_mode_sequencer_pkg.sv
// Shared types and helpers for the pixel-path mode sequencer.
// Mode encodings, FSM states and enable decode.
package proc_mode_sequencer_pkg;

  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_GREY = 3'b001;
  localparam logic [2:0] MODE_BLUR = 3'b101;
  localparam logic [2:0] MODE_EDGE = 3'b110;
  localparam logic [2:0] MODE_ZOOM = 3'b111;

  typedef enum logic [1:0] {
    RUN,
    PENDING,
    FLUSH,
    ARM
  } state_e;

  typedef struct packed {
    logic zoom;
    logic edg;
    logic blur;
    logic bright;
  } en_t;

  function automatic logic is_unsup(input logic [2:0] m);
    return (m == 3'b010) || (m == 3'b011) || (m == 3'b100);
  endfunction

  function automatic logic [2:0] map_mode(input logic [2:0] m);
    return is_unsup(m) ? MODE_PASS : m;
  endfunction

  function automatic en_t decode_en(input logic [2:0] m);
    en_t e;
    e        = '0;
    e.bright = (m == MODE_GREY);
    e.blur   = (m == MODE_BLUR);
    e.edg    = (m == MODE_EDGE);
    e.zoom   = (m == MODE_ZOOM);
    return e;
  endfunction

endpackage

// File: rtl/proc_mode_sequencer_switch_stabilizer.sv
// Synchronizes raw mode switches and accepts a value only after it
// has held steady; emits the accepted value and a 1-cycle pulse.
module switch_stabilizer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 250000,
  parameter int W             = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  output logic [W-1:0] acc_val,
  output logic         acc_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0]  sync_v;
  logic [W-1:0]  cand_q, cand_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // cnt counts samples of the candidate; it parks at STABLE_CYCLES
  // so a held value is accepted exactly once.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sw};
    sync_v  = sync_q[SYNC_STAGES-1];
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pulse_d = 1'b0;
    if (sync_v != cand_q) begin
      cand_d = sync_v;
      cnt_d  = CW'(1);
    end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
      cnt_d   = CW'(STABLE_CYCLES);
      acc_d   = cand_q;
      pulse_d = 1'b1;
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cand_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= CW'(STABLE_CYCLES);
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign acc_val   = acc_q;
  assign acc_pulse = pulse_q;

endmodule

// File: rtl/proc_mode_sequencer.sv
// Frame-synchronous processing-mode sequencer for the camera->VGA path.
// Mode changes wait for vsync fall, flush line buffers, then re-enable.
module proc_mode_sequencer
  import proc_mode_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 250000,
  parameter int FLUSH_CYCLES  = 16
) (
  input  logic       VGA_CLK,
  input  logic       RESET_N,
  input  logic [2:0] mode_sw,
  input  logic       vga_vs,
  input  logic       pixel_valid,
  output logic [2:0] mode_active,
  output logic       bright_en,
  output logic       blur_en,
  output logic       edge_en,
  output logic       zoom_en,
  output logic       pipe_flush,
  output logic       busy,
  output logic       unsupported,
  output logic [7:0] frame_count
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [2:0] acc_val;
  logic       acc_pulse;

  switch_stabilizer #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .W            (3)
  ) u_stab (
    .clk      (VGA_CLK),
    .rst_n    (RESET_N),
    .sw       (mode_sw),
    .acc_val  (acc_val),
    .acc_pulse(acc_pulse)
  );

  state_e        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [2:0]    target_q, target_d;
  logic          unsup_q, unsup_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    frame_q, frame_d;
  logic          flush_q, flush_d;
  logic          busy_q, busy_d;
  en_t           en_q, en_d;
  logic          vs_q;
  logic          frame_edge;
  logic [2:0]    req;

  always_comb begin
    frame_edge = vs_q & ~vga_vs;
    req        = map_mode(acc_val);
    state_d    = state_q;
    mode_d     = mode_q;
    target_d   = target_q;
    fcnt_d     = fcnt_q;
    flush_d    = 1'b0;
    unsup_d    = unsup_q;
    frame_d    = frame_q + {7'd0, frame_edge};
    if (acc_pulse) unsup_d = is_unsup(acc_val);
    unique case (state_q)
      RUN: begin
        if (req != mode_q) begin
          state_d  = PENDING;
          target_d = req;
        end
      end
      PENDING: begin
        if (acc_pulse && req == mode_q) begin
          state_d = RUN;
        end else begin
          if (acc_pulse) target_d = req;
          if (frame_edge) begin
            state_d = FLUSH;
            fcnt_d  = '0;
            flush_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == FW'(FLUSH_CYCLES - 1)) begin
          state_d = ARM;
          mode_d  = target_q;
        end else begin
          fcnt_d  = fcnt_q + 1'b1;
          flush_d = 1'b1;
        end
      end
      ARM: begin
        if (!pixel_valid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    busy_d = (state_d != RUN);
    // Old enables stay live while pending; dark from flush until RUN.
    en_d = (state_d == RUN || state_d == PENDING) ?
           decode_en(mode_d) : '0;
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= RUN;
      mode_q   <= MODE_PASS;
      target_q <= MODE_PASS;
      unsup_q  <= 1'b0;
      fcnt_q   <= '0;
      frame_q  <= '0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      en_q     <= '0;
      vs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      unsup_q  <= unsup_d;
      fcnt_q   <= fcnt_d;
      frame_q  <= frame_d;
      flush_q  <= flush_d;
      busy_q   <= busy_d;
      en_q     <= en_d;
      vs_q     <= vga_vs;
    end
  end

  assign mode_active = mode_q;
  assign bright_en   = en_q.bright;
  assign blur_en     = en_q.blur;
  assign edge_en     = en_q.edg;
  assign zoom_en     = en_q.zoom;
  assign pipe_flush  = flush_q;
  assign busy        = busy_q;
  assign unsupported = unsup_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_proc_mode_sequencer.sv
// Self-checking bench for proc_mode_sequencer: vector table with a
// scoreboard queue plus hand-written frame/flush/reset sequences.
module tb_proc_mode_sequencer;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int FLUSH  = 4;
  localparam int VS_PER = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] mode_sw;
  logic       vga_vs;
  logic       pixel_valid;
  logic [2:0] mode_active;
  logic       bright_en, blur_en, edge_en, zoom_en;
  logic       pipe_flush, busy, unsupported;
  logic [7:0] frame_count;
  logic [3:0] en_now;

  proc_mode_sequencer #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .VGA_CLK    (clk),
    .RESET_N    (rst_n),
    .mode_sw    (mode_sw),
    .vga_vs     (vga_vs),
    .pixel_valid(pixel_valid),
    .mode_active(mode_active),
    .bright_en  (bright_en),
    .blur_en    (blur_en),
    .edge_en    (edge_en),
    .zoom_en    (zoom_en),
    .pipe_flush (pipe_flush),
    .busy       (busy),
    .unsupported(unsupported),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  assign en_now = {zoom_en, edge_en, blur_en, bright_en};

  typedef struct {
    logic [2:0] sw;
    logic [2:0] mode;
    logic [3:0] en;
    logic       unsup;
    logic       flush;
  } vec_t;

  vec_t vecs[10];
  vec_t sbq[$];
  vec_t e;

  int         total = 0;
  int         bad = 0;
  int         vs_cnt;
  int         n, edges, guard;
  logic [7:0] exp_fc;
  logic       edge_pend;
  logic       fell;
  logic       flush_seen;
  logic       busy_seen;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // One cycle: drive vsync/pixel strobe on negedge, model frame_count.
  task automatic step();
    logic nv;
    @(negedge clk);
    if (edge_pend) begin
      exp_fc    = exp_fc + 8'd1;
      edge_pend = 1'b0;
    end
    vs_cnt = (vs_cnt == VS_PER - 1) ? 0 : vs_cnt + 1;
    nv     = (vs_cnt < 2) ? 1'b0 : 1'b1;
    fell   = vga_vs && !nv && rst_n;
    if (fell) edge_pend = 1'b1;
    vga_vs      = nv;
    pixel_valid = (vs_cnt >= 12 && vs_cnt < 90);
    if (pipe_flush) flush_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic wait_vs(input int v);
    int k;
    k = 0;
    while (vs_cnt != v && k < 200) begin
      step();
      k++;
    end
    chk("wait_vs_bound", int'(vs_cnt == v), 1);
  endtask

  initial begin
    vecs[0] = '{3'b101, 3'b101, 4'b0010, 1'b0, 1'b1};
    vecs[1] = '{3'b111, 3'b111, 4'b1000, 1'b0, 1'b1};
    vecs[2] = '{3'b001, 3'b001, 4'b0001, 1'b0, 1'b1};
    vecs[3] = '{3'b011, 3'b000, 4'b0000, 1'b1, 1'b1};
    vecs[4] = '{3'b100, 3'b000, 4'b0000, 1'b1, 1'b0};
    vecs[5] = '{3'b001, 3'b001, 4'b0001, 1'b0, 1'b1};
    vecs[6] = '{3'b010, 3'b000, 4'b0000, 1'b1, 1'b1};
    vecs[7] = '{3'b000, 3'b000, 4'b0000, 1'b0, 1'b0};
    vecs[8] = '{3'b110, 3'b110, 4'b0100, 1'b0, 1'b1};
    vecs[9] = '{3'b111, 3'b111, 4'b1000, 1'b0, 1'b1};

    rst_n       = 1'b0;
    mode_sw     = 3'b000;
    vga_vs      = 1'b1;
    pixel_valid = 1'b0;
    vs_cnt      = 50;
    exp_fc      = '0;
    edge_pend   = 1'b0;
    flush_seen  = 1'b0;
    busy_seen   = 1'b0;
    repeat (3) step();
    chk("rst_mode", mode_active, 0);
    chk("rst_en", en_now, 0);
    chk("rst_flush", pipe_flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_unsup", unsupported, 0);
    chk("rst_fc", frame_count, 0);
    rst_n = 1'b1;

    // Idle: frame counter tracks vsync falls.
    for (int f = 0; f < 3; f++) begin
      repeat (VS_PER) step();
      chk("frame_count", frame_count, exp_fc);
    end
    chk("frames_3", frame_count, 3);
    chk("idle_busy", busy_seen, 0);
    chk("idle_en", en_now, 0);

    // Short glitch must never be accepted.
    wait_vs(20);
    busy_seen  = 1'b0;
    flush_seen = 1'b0;
    mode_sw    = 3'b110;
    repeat (5) step();
    mode_sw = 3'b000;
    repeat (150) step();
    chk("glitch_busy", busy_seen, 0);
    chk("glitch_flush", flush_seen, 0);
    chk("glitch_mode", mode_active, 0);

    // Cancel while pending.
    wait_vs(20);
    mode_sw = 3'b101;
    n = 0;
    while (!busy && n < 30) begin
      step();
      n++;
    end
    chk("pend_busy", busy, 1);
    mode_sw = 3'b000;
    repeat (15) step();
    chk("cancel_busy", busy, 0);
    flush_seen = 1'b0;
    repeat (120) step();
    chk("cancel_flush", flush_seen, 0);
    chk("cancel_mode", mode_active, 0);
    chk("cancel_blur", blur_en, 0);

    // 000 -> 110 with acceptance latency and flush timing.
    wait_vs(20);
    mode_sw = 3'b110;
    n = 0;
    while (!busy && n < 30) begin
      step();
      n++;
    end
    chk("accept_latency_in_window",
        int'(n >= SYNC + STABLE && n <= SYNC + STABLE + 2), 1);
    chk("pend_edge_en_held", edge_en, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!fell && n < 150);
    chk("vs_edge_bound", fell, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("flush_c%0d", k), pipe_flush, int'(k <= FLUSH));
      chk($sformatf("edge_en_c%0d", k), edge_en, int'(k >= FLUSH + 2));
      if (k == FLUSH + 1) begin
        chk("arm_mode", mode_active, 3'b110);
        chk("arm_busy", busy, 1);
      end
    end
    chk("run_busy", busy, 0);

    // Table of mode requests through the scoreboard.
    for (int i = 0; i < 10; i++) begin
      mode_sw = vecs[i].sw;
      sbq.push_back(vecs[i]);
      flush_seen = 1'b0;
      repeat (220) step();
      e = sbq.pop_front();
      chk($sformatf("v%0d_mode", i), mode_active, e.mode);
      chk($sformatf("v%0d_en", i), en_now, e.en);
      chk($sformatf("v%0d_unsup", i), unsupported, e.unsup);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_flush", i), flush_seen, e.flush);
    end

    // Async reset in the middle of a flush.
    mode_sw = 3'b000;
    n = 0;
    while (!pipe_flush && n < 250) begin
      step();
      n++;
    end
    chk("pre_rst_flush", pipe_flush, 1);
    step();
    chk("pre_rst_flush2", pipe_flush, 1);
    chk("pre_rst_mode", mode_active, 3'b111);
    #2;
    rst_n     = 1'b0;
    edge_pend = 1'b0;
    exp_fc    = '0;
    #1;
    chk("arst_flush", pipe_flush, 0);
    chk("arst_mode", mode_active, 0);
    chk("arst_busy", busy, 0);
    chk("arst_en", en_now, 0);
    chk("arst_fc", frame_count, 0);
    repeat (2) step();
    rst_n = 1'b1;

    // 256 frames wrap the counter.
    edges = 0;
    guard = 0;
    while (edges < 255 && guard < 30000) begin
      step();
      guard++;
      if (fell) edges++;
    end
    step();
    chk("fc_255", frame_count, 255);
    while (edges < 256 && guard < 30000) begin
      step();
      guard++;
      if (fell) edges++;
    end
    step();
    chk("edges_bound", edges, 256);
    chk("fc_wrap", frame_count, 0);
    chk("fc_model", frame_count, exp_fc);
    chk("final_en", en_now, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
